pulse_stretcher: RTL and testbench

- Output-direction counterpart of the input debouncer. It converts single-cycle internal event strobes (for example UART byte received, or a CPU CSR write) into human-visible, fixed-length pulses on board LEDs or other slow external pins.
- Each channel is independent. Each guarantees a minimum high time and a minimum low gap, and buffers one event that arrives while the channel is busy.
- Sits between core/IO logic and the top-level LED pins.

---
 rtl/pulse_stretcher_pkg.sv | 24 ++
 rtl/pulse_stretch_channel.sv | 101 ++++++++++
 rtl/pulse_stretcher.sv | 37 +++
 tb/tb_pulse_stretcher.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pulse_stretcher_pkg.sv
// Shared definitions for the pulse stretcher: channel FSM encoding and sizing helpers.
package pulse_stretcher_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } ps_state_e;

    function automatic int unsigned ps_max(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned ps_log2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/pulse_stretch_channel.sv
// One stretcher channel: IDLE/HOLD/GAP FSM with hold/gap counter, one-deep pending and sticky overrun.
module pulse_stretch_channel
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned hold_count_max = 1250000,
    parameter int unsigned gap_count_max  = 250000,
    parameter bit          retrigger      = 1'b0,
    parameter int unsigned counter_width  = ps_log2(ps_max(hold_count_max, gap_count_max))
) (
    input  logic clk,
    input  logic rst_n,
    input  logic event_pulse,
    input  logic clear_overrun,
    output logic stretched_signal,
    output logic busy,
    output logic overrun
);

    localparam logic [counter_width-1:0] hold_last = counter_width'(hold_count_max - 1);
    localparam logic [counter_width-1:0] gap_last  = counter_width'(gap_count_max - 1);

    ps_state_e                state;
    logic [counter_width-1:0] count;
    logic                     pending;
    logic                     overrun_set_c;

    // An event that would need the pending slot while it is already occupied is dropped.
    always_comb begin
        overrun_set_c = 1'b0;
        if (event_pulse && pending) begin
            overrun_set_c = ((state == ST_HOLD) && !retrigger) || (state == ST_GAP);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state            <= ST_IDLE;
            count            <= '0;
            pending          <= 1'b0;
            stretched_signal <= 1'b0;
            busy             <= 1'b0;
            overrun          <= 1'b0;
        end else begin
            if (overrun_set_c) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (event_pulse) begin
                        state            <= ST_HOLD;
                        count            <= '0;
                        stretched_signal <= 1'b1;
                        busy             <= 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (retrigger && event_pulse) begin
                        count <= '0;
                    end else begin
                        if (event_pulse) pending <= 1'b1;
                        if (count == hold_last) begin
                            state            <= ST_GAP;
                            count            <= '0;
                            stretched_signal <= 1'b0;
                        end else begin
                            count <= count + counter_width'(1);
                        end
                    end
                end
                ST_GAP: begin
                    if (count == gap_last) begin
                        // Buffered or same-cycle event starts the next pulse with no idle cycle.
                        count   <= '0;
                        pending <= 1'b0;
                        if (pending || event_pulse) begin
                            state            <= ST_HOLD;
                            stretched_signal <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        count <= count + counter_width'(1);
                        if (event_pulse) pending <= 1'b1;
                    end
                end
                default: begin
                    state            <= ST_IDLE;
                    count            <= '0;
                    pending          <= 1'b0;
                    stretched_signal <= 1'b0;
                    busy             <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pulse_stretcher.sv
// Bank of independent pulse stretcher channels driving slow external pins.
module pulse_stretcher
    import pulse_stretcher_pkg::*;
#(
    parameter int unsigned width          = 1,
    parameter int unsigned hold_count_max = 1250000,
    parameter int unsigned gap_count_max  = 250000,
    parameter bit          retrigger      = 1'b0,
    parameter int unsigned counter_width  = ps_log2(ps_max(hold_count_max, gap_count_max))
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [width-1:0] event_pulse,
    input  logic [width-1:0] clear_overrun,
    output logic [width-1:0] stretched_signal,
    output logic [width-1:0] busy,
    output logic [width-1:0] overrun
);

    for (genvar i = 0; i < int'(width); i++) begin : g_ch
        pulse_stretch_channel #(
            .hold_count_max (hold_count_max),
            .gap_count_max  (gap_count_max),
            .retrigger      (retrigger),
            .counter_width  (counter_width)
        ) u_ch (
            .clk              (clk),
            .rst_n            (rst_n),
            .event_pulse      (event_pulse[i]),
            .clear_overrun    (clear_overrun[i]),
            .stretched_signal (stretched_signal[i]),
            .busy             (busy[i]),
            .overrun          (overrun[i])
        );
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Directed bench: two-channel non-retriggering instance and one-channel retriggering instance, hold=4, gap=2.
module tb_pulse_stretcher;

    logic       clk;
    logic       rst_n;
    logic [1:0] ev_nr, clr_nr;
    logic [1:0] out_nr, bsy_nr, ovr_nr;
    logic [0:0] ev_rt, clr_rt;
    logic [0:0] out_rt, bsy_rt, ovr_rt;

    int n_vec = 0;
    int n_err = 0;

    pulse_stretcher #(
        .width(2), .hold_count_max(4), .gap_count_max(2), .retrigger(1'b0)
    ) u_dut_nr (
        .clk(clk), .rst_n(rst_n), .event_pulse(ev_nr), .clear_overrun(clr_nr),
        .stretched_signal(out_nr), .busy(bsy_nr), .overrun(ovr_nr)
    );

    pulse_stretcher #(
        .width(1), .hold_count_max(4), .gap_count_max(2), .retrigger(1'b1)
    ) u_dut_rt (
        .clk(clk), .rst_n(rst_n), .event_pulse(ev_rt), .clear_overrun(clr_rt),
        .stretched_signal(out_rt), .busy(bsy_rt), .overrun(ovr_rt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Bit i of ev* is sampled at edge i; bit i of exp*/bsy* is the output after edge i.
    task automatic run_seq(input string tag, input int n, input bit use_rt,
                           input logic [31:0] ev0, input logic [31:0] ev1,
                           input logic [31:0] exp0, input logic [31:0] bsy0,
                           input logic [31:0] exp1, input logic [31:0] bsy1);
        for (int i = 0; i < n; i++) begin
            if (use_rt) ev_rt[0] = ev0[i];
            else        ev_nr    = {ev1[i], ev0[i]};
            tick();
            ev_rt = '0;
            ev_nr = '0;
            if (use_rt) begin
                check($sformatf("%s_out[%0d]", tag, i),  32'(out_rt[0]), 32'(exp0[i]));
                check($sformatf("%s_busy[%0d]", tag, i), 32'(bsy_rt[0]), 32'(bsy0[i]));
            end else begin
                check($sformatf("%s_out0[%0d]", tag, i),  32'(out_nr[0]), 32'(exp0[i]));
                check($sformatf("%s_busy0[%0d]", tag, i), 32'(bsy_nr[0]), 32'(bsy0[i]));
                check($sformatf("%s_out1[%0d]", tag, i),  32'(out_nr[1]), 32'(exp1[i]));
                check($sformatf("%s_busy1[%0d]", tag, i), 32'(bsy_nr[1]), 32'(bsy1[i]));
            end
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n  = 1'b0;
        ev_nr  = '0;
        clr_nr = '0;
        ev_rt  = '0;
        clr_rt = '0;
        #1;
        check("rst_out_nr", 32'(out_nr), 32'h0);
        check("rst_busy_nr", 32'(bsy_nr), 32'h0);
        check("rst_ovr_nr", 32'(ovr_nr), 32'h0);
        check("rst_out_rt", 32'(out_rt), 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Single event, then identical repeat at +10.
        run_seq("single", 17, 1'b0, 32'h0401, 32'h0, 32'h3C0F, 32'hFC3F, 32'h0, 32'h0);

        // Buffered second event follows after exactly one gap.
        run_seq("pend", 13, 1'b0, 32'h0005, 32'h0, 32'h03CF, 32'h0FFF, 32'h0, 32'h0);
        check("pend_ovr", 32'(ovr_nr[0]), 32'h0);

        // Retrigger mid-hold: 7 high, 2 gap, idle.
        run_seq("retrig", 10, 1'b1, 32'h0009, 32'h0, 32'h007F, 32'h01FF, 32'h0, 32'h0);
        // Retrigger on last hold cycle stretches to 8 high.
        run_seq("retrig_last", 11, 1'b1, 32'h0011, 32'h0, 32'h00FF, 32'h03FF, 32'h0, 32'h0);
        check("retrig_ovr", 32'(ovr_rt[0]), 32'h0);

        // Three events: one pending pulse, third dropped.
        run_seq("ovr", 13, 1'b0, 32'h0007, 32'h0, 32'h03CF, 32'h0FFF, 32'h0, 32'h0);
        check("ovr_set", 32'(ovr_nr[0]), 32'h1);
        check("ovr_ch1_clean", 32'(ovr_nr[1]), 32'h0);

        clr_nr = 2'b01;
        tick();
        clr_nr = '0;
        check("ovr_cleared", 32'(ovr_nr[0]), 32'h0);

        // Clear coincident with a new drop: set wins.
        ev_nr = 2'b01;
        tick();
        tick();
        check("ovr_before_drop", 32'(ovr_nr[0]), 32'h0);
        clr_nr = 2'b01;
        tick();
        ev_nr  = '0;
        clr_nr = '0;
        check("ovr_set_wins", 32'(ovr_nr[0]), 32'h1);
        check("mid_hold_out", 32'(out_nr[0]), 32'h1);

        // Asynchronous reset mid-hold, between edges.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out", 32'(out_nr[0]), 32'h0);
        check("arst_busy", 32'(bsy_nr[0]), 32'h0);
        check("arst_ovr", 32'(ovr_nr[0]), 32'h0);
        tick();
        rst_n = 1'b1;
        run_seq("post_rst", 12, 1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);

        // Two channels offset by three cycles.
        run_seq("dual", 12, 1'b0, 32'h0001, 32'h0008, 32'h000F, 32'h003F, 32'h0078, 32'h01F8);
        check("dual_ovr", 32'(ovr_nr), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
